// File: rtl/another_vid_ctrl.sv
// another_vid_ctrl: Wishbone-slave display controller with a queued frame-base FIFO and on-chip palette.
// Latency: bus ack and read data one cycle after access; frame pop lands one cycle after vsync; palette scanout one cycle.
// Backpressure: none on the bus (every access acks); frame pushes into a full FIFO with no pop are dropped and counted.
//
// Ports:
//   wb_clk, wb_rst          clock, asynchronous active-high reset
//   i_wb_* / o_wb_*         Wishbone slave (adr, dat, we, cyc in; rdt, ack out)
//   i_vsync                 vertical sync, pops the next queued frame
//   o_frame_adr/new/fifo_full  current frame base, change pulse, FIFO full flag
//   i_pal_idx / o_pal_dat   scanout palette read (registered)
//   o_pal_upd               pulse on any palette write
//
// Optional macro ANOTHER_VID_CTRL_STATUS_EN: enables region 4'h3 status read,
// drop counter, and flush/clear on write with bit 31 set.

module another_vid_ctrl #(
  parameter int          FIFO_DEPTH  = 4,
  parameter int          PAL_AW      = 4,
  parameter int          PAL_DW      = 16,
  parameter logic [31:0] RESET_FRAME = 32'h0000_0000
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic [31:0]       i_wb_adr,
  input  logic [31:0]       i_wb_dat,
  input  logic              i_wb_we,
  input  logic              i_wb_cyc,
  output logic [31:0]       o_wb_rdt,
  output logic              o_wb_ack,
  input  logic              i_vsync,
  output logic [31:0]       o_frame_adr,
  output logic              o_frame_new,
  output logic              o_fifo_full,
  input  logic [PAL_AW-1:0] i_pal_idx,
  output logic [PAL_DW-1:0] o_pal_dat,
  output logic              o_pal_upd
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PAL_DW-1:0] pal_mem  [2**PAL_AW];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level, level_nxt;

  logic              access, wr_en, push_req, push, pop, full_now, flush;
  logic [3:0]        region;
  logic [PAL_AW-1:0] pal_bus_idx;
  logic [31:0]       rdata;

  // Only part of the address/data buses is decoded.
  logic unused_bits;
  assign unused_bits = ^{i_wb_adr, i_wb_dat};

  // An access is taken on the first cycle of cyc; the ack cycle itself is not a new access.
  assign access      = i_wb_cyc & ~o_wb_ack;
  assign wr_en       = access & i_wb_we;
  assign region      = i_wb_adr[31:28];
  assign pal_bus_idx = i_wb_adr[PAL_AW+1:2];
  assign full_now    = (level == LW'(FIFO_DEPTH));
  assign push_req    = wr_en & (region == 4'h1);

`ifdef ANOTHER_VID_CTRL_STATUS_EN
  logic [15:0] drop_cnt;
  logic        drop;
  assign flush = wr_en & (region == 4'h3) & i_wb_dat[31];
  assign drop  = push_req & full_now & ~pop;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst)                          drop_cnt <= 16'h0000;
    else if (flush)                      drop_cnt <= 16'h0000;
    else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'h0001;
  end
`else
  assign flush = 1'b0;
`endif

  // Empty FIFO never pops, so a push in the same cycle is not bypassed.
  // A full FIFO accepts a push only when the head leaves the same cycle.
  assign pop  = i_vsync & (level != '0) & ~flush;
  assign push = push_req & (~full_now | pop);

  always_comb begin
    level_nxt = level;
    if (flush) level_nxt = '0;
    else begin
      case ({push, pop})
        2'b10:   level_nxt = level + LW'(1);
        2'b01:   level_nxt = level - LW'(1);
        default: level_nxt = level;
      endcase
    end
  end

  always_comb begin
    rdata = 32'h0;
    case (region)
      4'h1: rdata = o_frame_adr;
      4'h2: rdata[PAL_DW-1:0] = pal_mem[pal_bus_idx];
`ifdef ANOTHER_VID_CTRL_STATUS_EN
      4'h3: rdata = {drop_cnt, 7'b0, full_now, 8'(level)};
`endif
      default: rdata = 32'h0;
    endcase
  end

  // Storage arrays carry no reset.
  always_ff @(posedge wb_clk) begin
    if (push) fifo_mem[wr_ptr] <= i_wb_dat;
    if (wr_en && region == 4'h2) pal_mem[pal_bus_idx] <= i_wb_dat[PAL_DW-1:0];
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      o_wb_ack    <= 1'b0;
      o_wb_rdt    <= 32'h0;
      o_frame_adr <= RESET_FRAME;
      o_frame_new <= 1'b0;
      o_fifo_full <= 1'b0;
      o_pal_dat   <= '0;
      o_pal_upd   <= 1'b0;
      level       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      o_wb_ack    <= access;
      if (access) o_wb_rdt <= rdata;
      o_pal_upd   <= wr_en & (region == 4'h2);
      // Read-before-write: a same-cycle bus write to this index is seen next cycle.
      o_pal_dat   <= pal_mem[i_pal_idx];
      o_frame_new <= pop;
      if (pop) begin
        o_frame_adr <= fifo_mem[rd_ptr];
        rd_ptr      <= rd_ptr + PW'(1);
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end
      level       <= level_nxt;
      o_fifo_full <= (level_nxt == LW'(FIFO_DEPTH));
    end
  end

endmodule
